// File: rtl/key_debounce_pkg.sv
// Shared types and constants for the key debouncer: FSM state encoding and synchronizer depth.
package key_debounce_pkg;

    localparam int SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_e;

endpackage

// File: rtl/key_debounce_sync_2ff.sv
// Two-flop synchronizer bringing the raw asynchronous key level into the sysclk domain.
module sync_2ff
    import key_debounce_pkg::*;
(
    input  logic sysclk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/key_debounce.sv
// Mechanical key debouncer: a level change is accepted only after STABLE_CYCLES of stable input.
// Define KEY_DEBOUNCE_RELEASE_PULSE_EN to generate the key_release strobe; otherwise it is tied to 0.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = 1000000,
    parameter int CNT_WIDTH     = 20
) (
    input  logic sysclk,
    input  logic reset,
    input  logic key_in,
    output logic key_out,
    output logic key_pulse,
    output logic key_release
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

    logic                 ks;
    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 key_out_q, key_out_d;
    logic                 pulse_q, pulse_d;

    sync_2ff u_sync (
        .sysclk (sysclk),
        .reset  (reset),
        .d      (key_in),
        .q      (ks)
    );

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // cnt only runs in the two wait states and is cleared on every exit, so it never wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            IDLE: begin
                if (ks) state_d = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (!ks)                   state_d = IDLE;
                else if (cnt_q == CNT_LAST) state_d = HELD;
                else                        cnt_d   = cnt_q + CNT_WIDTH'(1);
            end
            HELD: begin
                if (!ks) state_d = RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
                if (ks)                     state_d = HELD;
                else if (cnt_q == CNT_LAST) state_d = IDLE;
                else                        cnt_d   = cnt_q + CNT_WIDTH'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they change on the accepting edge.
    always_comb begin
        key_out_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
        pulse_d   = (state_q == PRESS_WAIT) && (state_d == HELD);
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            key_out_q <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            key_out_q <= key_out_d;
            pulse_q   <= pulse_d;
        end
    end

    assign key_out   = key_out_q;
    assign key_pulse = pulse_q;

`ifdef KEY_DEBOUNCE_RELEASE_PULSE_EN
    logic release_q, release_d;

    always_comb begin
        release_d = (state_q == RELEASE_WAIT) && (state_d == IDLE);
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            release_q <= 1'b0;
        end else begin
            release_q <= release_d;
        end
    end

    assign key_release = release_q;
`else
    assign key_release = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Randomized self-checking bench for key_debounce against a run-length reference model.
module tb_key_debounce;

    localparam int STABLE = 4;
    localparam int LAT    = STABLE + 3;
`ifdef KEY_DEBOUNCE_RELEASE_PULSE_EN
    localparam int REL_EXP = 1;
`else
    localparam int REL_EXP = 0;
`endif

    logic sysclk = 1'b0;
    logic reset  = 1'b0;
    logic key_in = 1'b0;
    logic key_out, key_pulse, key_release;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: two-edge input delay plus a run-length count of disagreeing samples.
    logic h0, h1, m_lvl, m_pulse, m_rel;
    int   m_run;

    int   n_stable, rise_n, fall_n, pulse_cnt, rel_cnt;
    logic prev_out;

    always #5 sysclk = ~sysclk;

    key_debounce #(
        .STABLE_CYCLES (STABLE),
        .CNT_WIDTH     (3)
    ) dut (
        .sysclk      (sysclk),
        .reset       (reset),
        .key_in      (key_in),
        .key_out     (key_out),
        .key_pulse   (key_pulse),
        .key_release (key_release)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        h0 = 1'b0; h1 = 1'b0; m_lvl = 1'b0; m_pulse = 1'b0; m_rel = 1'b0; m_run = 0;
    endtask

    task automatic model_edge(input logic kin);
        logic seen;
        seen = h1;
        h1 = h0;
        h0 = kin;
        m_pulse = 1'b0;
        m_rel   = 1'b0;
        if (seen !== m_lvl) begin
            m_run++;
            if (m_run == STABLE + 1) begin
                m_lvl   = seen;
                m_run   = 0;
                m_pulse = seen;
`ifdef KEY_DEBOUNCE_RELEASE_PULSE_EN
                m_rel   = ~seen;
`endif
            end
        end else begin
            m_run = 0;
        end
    endtask

    task automatic clr_stats();
        rise_n = 0; fall_n = 0; pulse_cnt = 0; rel_cnt = 0;
    endtask

    // Drive one input value for one clock, then compare against the model on the falling edge.
    task automatic tick(input logic kin);
        if (kin !== key_in) n_stable = 1;
        else                n_stable++;
        key_in = kin;
        @(posedge sysclk);
        model_edge(kin);
        @(negedge sysclk);
        check_eq("key_out", 32'(key_out), 32'(m_lvl));
        check_eq("key_pulse", 32'(key_pulse), 32'(m_pulse));
        check_eq("key_release", 32'(key_release), 32'(m_rel));
        check_eq("strobe_excl", 32'(key_pulse & key_release), 32'd0);
        if (key_out && !prev_out) rise_n = n_stable;
        if (!key_out && prev_out) fall_n = n_stable;
        prev_out  = key_out;
        pulse_cnt += int'(key_pulse);
        rel_cnt   += int'(key_release);
    endtask

    task automatic apply_reset(input int cycles);
        #2 reset = 1'b0;
        #1;
        check_eq("rst_key_out", 32'(key_out), 32'd0);
        check_eq("rst_key_pulse", 32'(key_pulse), 32'd0);
        check_eq("rst_key_release", 32'(key_release), 32'd0);
        model_reset();
        repeat (cycles) @(posedge sysclk);
        @(negedge sysclk);
        reset    = 1'b1;
        n_stable = 0;
        prev_out = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        n_stable = 0;
        prev_out = 1'b0;
        clr_stats();

        // Reset held with the key already pressed.
        reset  = 1'b0;
        key_in = 1'b1;
        repeat (3) @(posedge sysclk);
        @(negedge sysclk);
        check_eq("por_key_out", 32'(key_out), 32'd0);
        check_eq("por_key_pulse", 32'(key_pulse), 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) tick(1'b1);
        check_eq("por_rise_lat", 32'(rise_n), 32'(LAT));
        check_eq("por_pulses", 32'(pulse_cnt), 32'd1);
        $display("scenario reset_release: rise after %0d edges, %0d pulses", rise_n, pulse_cnt);

        // Stable release from HELD.
        clr_stats();
        for (int i = 0; i < 12; i++) tick(1'b0);
        check_eq("rel_fall_lat", 32'(fall_n), 32'(LAT));
        check_eq("rel_strobes", 32'(rel_cnt), 32'(REL_EXP));
        check_eq("rel_pulses", 32'(pulse_cnt), 32'd0);
        $display("scenario release: fall after %0d edges, %0d release strobes", fall_n, rel_cnt);

        // Short press shorter than the qualification window.
        clr_stats();
        for (int i = 0; i < 3; i++)  tick(1'b1);
        for (int i = 0; i < 10; i++) tick(1'b0);
        check_eq("short_rise", 32'(rise_n), 32'd0);
        check_eq("short_pulses", 32'(pulse_cnt), 32'd0);
        check_eq("short_rel", 32'(rel_cnt), 32'd0);
        $display("scenario short_press: %0d pulses", pulse_cnt);

        // Bouncing every 2 cycles, then settle high.
        clr_stats();
        for (int i = 0; i < 20; i++) tick(((i / 2) % 2) == 0);
        for (int i = 0; i < 10; i++) tick(1'b1);
        check_eq("bounce_pulses", 32'(pulse_cnt), 32'd1);
        check_eq("bounce_rise_lat", 32'(rise_n), 32'(LAT));
        $display("scenario bounce: rise after %0d edges, %0d pulses", rise_n, pulse_cnt);

        // Long hold from IDLE: one pulse only, counter parked at 0 while held.
        for (int i = 0; i < 12; i++) tick(1'b0);
        clr_stats();
        for (int i = 0; i < 100; i++) begin
            tick(1'b1);
            if (m_lvl && m_run == 0) check_eq("cnt_held", 32'(dut.cnt_q), 32'd0);
        end
        check_eq("hold_pulses", 32'(pulse_cnt), 32'd1);
        check_eq("hold_key_out", 32'(key_out), 32'd1);
        $display("scenario long_hold: %0d pulses, key_out=%0d", pulse_cnt, key_out);

        // Reset while HELD must drop key_out without a clock edge.
        apply_reset(2);

        // Reset mid-count in PRESS_WAIT (cnt=2), key stays pressed.
        for (int i = 0; i < 5; i++) tick(1'b1);
        apply_reset(1);
        clr_stats();
        for (int i = 0; i < 10; i++) tick(1'b1);
        check_eq("midrst_rise_lat", 32'(rise_n), 32'(LAT));
        check_eq("midrst_pulses", 32'(pulse_cnt), 32'd1);
        $display("scenario mid_count_reset: rise after %0d edges", rise_n);

        // Random bouncy runs checked cycle by cycle against the model.
        clr_stats();
        begin
            logic v;
            int   len;
            int   cyc;
            v   = 1'b0;
            cyc = 0;
            while (cyc < 3000) begin
                len = int'($urandom_range(1, 2 * STABLE + 3));
                for (int k = 0; k < len; k++) tick(v);
                cyc += len;
                v = ~v;
            end
        end
        $display("scenario random: %0d pulses, %0d release strobes", pulse_cnt, rel_cnt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
